// File: rtl/g2_packetizer.sv
// Frames the g2 histogram readout into a byte stream: sync bytes, sequence
// number, big-endian bin words and an 8-bit additive checksum.
module g2_packetizer #(
  parameter int         iSIZE      = 32-1,
  parameter int         binAddrBit = 10-1,
  parameter logic [7:0] SYNC0      = 8'hA5,
  parameter logic [7:0] SYNC1      = 8'h5A
) (
  input  logic           clk,
  input  logic           RST,
  input  logic [iSIZE:0] iD,
  input  logic           iV,
  output logic           iR,
  output logic [7:0]     oD,
  output logic           oV,
  input  logic           oR,
  output logic           oFrameDone
);

  localparam int BPW = (iSIZE + 1) / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BW-1:0]       LAST_BYTE = BW'(BPW - 1);
  localparam logic [binAddrBit:0] LAST_BIN  = '1;

  typedef enum logic [2:0] {S_IDLE, S_SYNC0, S_SYNC1, S_SEQ, S_DATA, S_CSUM} state_t;

  state_t              state_q, state_d;
  logic [7:0]          seq_q, seq_d;
  logic [binAddrBit:0] bin_q, bin_d;
  logic [BW-1:0]       byte_idx_q, byte_idx_d;
  logic [iSIZE:0]      word_q, word_d;
  logic                loaded_q, loaded_d;
  logic [7:0]          csum_q, csum_d;
  logic                frame_done_q, frame_done_d;

  logic [iSIZE:0]      word_shifted;
  logic [7:0]          data_byte;
  logic                last_byte, last_bin, byte_xfer, word_xfer;

  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  // Byte byte_idx of the held word, most significant byte first.
  assign word_shifted = word_q >> {LAST_BYTE - byte_idx_q, 3'b000};
  assign data_byte    = word_shifted[7:0];
  assign last_byte    = (byte_idx_q == LAST_BYTE);
  assign last_bin     = (bin_q == LAST_BIN);
  assign byte_xfer    = oV && oR;
  assign word_xfer    = iV && iR;
  assign oFrameDone   = frame_done_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iV) state_d = S_SYNC0;
      S_SYNC0: if (oR) state_d = S_SYNC1;
      S_SYNC1: if (oR) state_d = S_SEQ;
      S_SEQ:   if (oR) state_d = S_DATA;
      S_DATA:  if (byte_xfer && last_byte && last_bin) state_d = S_CSUM;
      S_CSUM:  if (oR) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The reload path lets the next word land on the edge that sends the last
  // byte of the current one, except after the final bin of the frame.
  always_comb begin
    oV = 1'b0;
    oD = 8'h00;
    iR = 1'b0;
    case (state_q)
      S_SYNC0: begin oV = 1'b1; oD = SYNC0; end
      S_SYNC1: begin oV = 1'b1; oD = SYNC1; end
      S_SEQ:   begin oV = 1'b1; oD = seq_q; end
      S_DATA: begin
        oV = loaded_q;
        oD = loaded_q ? data_byte : 8'h00;
        iR = !loaded_q || (last_byte && oR && !last_bin);
      end
      S_CSUM:  begin oV = 1'b1; oD = csum_q; end
      default: ;
    endcase
  end

  always_comb begin
    seq_d        = seq_q;
    bin_d        = bin_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    loaded_d     = loaded_q;
    csum_d       = csum_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_SEQ: if (oR) begin
        csum_d     = seq_q;
        bin_d      = '0;
        byte_idx_d = '0;
        loaded_d   = 1'b0;
      end
      S_DATA: begin
        if (byte_xfer) begin
          csum_d = csum_add(csum_q, oD);
          if (last_byte) begin
            loaded_d   = 1'b0;
            byte_idx_d = '0;
            bin_d      = bin_q + 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
        if (word_xfer) begin
          word_d     = iD;
          loaded_d   = 1'b1;
          byte_idx_d = '0;
        end
      end
      S_CSUM: if (oR) begin
        seq_d        = seq_q + 8'd1;
        frame_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      seq_q        <= 8'h00;
      bin_q        <= '0;
      byte_idx_q   <= '0;
      loaded_q     <= 1'b0;
      csum_q       <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      seq_q        <= seq_d;
      bin_q        <= bin_d;
      byte_idx_q   <= byte_idx_d;
      loaded_q     <= loaded_d;
      csum_q       <= csum_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

endmodule
